// File: rtl/phys_step_sequencer.sv
// Per-frame physics sweep: fetch each active object word, hand it to the update stage, write the result back.
// Optional PHYS_FLOOR_CLAMP_EN clamps written pos_y to FLOOR_Y (and zeroes vel_y) when the result falls below the floor.

`ifndef SF
`define SF 16
`endif
`ifndef SF_DEC
`define SF_DEC 8
`endif
`ifndef DF_DEC
`define DF_DEC 8
`endif
`ifndef OBJ_DYN_WIDTH
`define OBJ_DYN_WIDTH (4*`SF)
`endif

// state | meaning
// IDLE  | waiting for start
// SCAN  | test mask[idx]; issue read, skip slot, or finish
// WAIT  | read in flight; capture rd_data on the last wait cycle
// CALC  | update stage evaluates upd_dyn; result registered
// WRITE | write result back, advance idx
// DONE  | one-cycle completion pulse
module phys_step_sequencer #(
    parameter int NUM_OBJ = 16,
    parameter int ADDR_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    parameter int RD_LAT = 2,
    parameter logic signed [`SF-1:0] FLOOR_Y = 16'sd1000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        start,
    input  logic signed [`DF_DEC+1:0]   time_step,
    input  logic [NUM_OBJ-1:0]          obj_active,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [`OBJ_DYN_WIDTH-1:0]   rd_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [`OBJ_DYN_WIDTH-1:0]   wr_data,
    output logic [`OBJ_DYN_WIDTH-1:0]   upd_dyn,
    output logic signed [`DF_DEC+1:0]   upd_time_step,
    input  logic [`OBJ_DYN_WIDTH-1:0]   upd_result
);

    localparam int IDX_W  = ADDR_W + 1;
    localparam int MASK_W = 1 << ADDR_W;
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WAIT  = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                      state, state_next;
    logic [IDX_W-1:0]            idx;
    logic [CNT_W-1:0]            cnt;
    logic [MASK_W-1:0]           mask_q;
    logic                        at_end;
    logic                        slot_on;
    logic                        last_wait;
    logic [`OBJ_DYN_WIDTH-1:0]   calc_word;

    assign at_end    = (idx == IDX_W'(NUM_OBJ));
    assign slot_on   = !at_end && mask_q[idx[ADDR_W-1:0]];
    assign last_wait = (cnt == CNT_W'(1));
    assign rd_addr   = idx[ADDR_W-1:0];
    assign wr_addr   = idx[ADDR_W-1:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                if (at_end) begin
                    state_next = DONE;
                end else if (slot_on) begin
                    rd_en      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (last_wait) state_next = CALC;
            end
            CALC: begin
                state_next = WRITE;
            end
            WRITE: begin
                wr_en      = 1'b1;
                state_next = SCAN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result word as it will be written; the floor clamp only touches the y axis.
    always_comb begin
        calc_word = upd_result;
`ifdef PHYS_FLOOR_CLAMP_EN
        if ($signed(upd_result[3*`SF-1:2*`SF]) > FLOOR_Y) begin
            calc_word[3*`SF-1:2*`SF] = FLOOR_Y;
            calc_word[`SF-1:0]       = '0;
        end
`endif
    end

`ifndef PHYS_FLOOR_CLAMP_EN
    logic unused_floor_y;
    assign unused_floor_y = ^FLOOR_Y;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx           <= '0;
            cnt           <= '0;
            mask_q        <= '0;
            upd_time_step <= '0;
            upd_dyn       <= '0;
            wr_data       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        upd_time_step <= time_step;
                        mask_q        <= MASK_W'(obj_active);
                        idx           <= '0;
                    end
                end
                SCAN: begin
                    if (slot_on) begin
                        cnt <= CNT_W'(RD_LAT);
                    end else if (!at_end) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_wait) upd_dyn <= rd_data;
                end
                CALC: begin
                    wr_data <= calc_word;
                end
                WRITE: begin
                    idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phys_step_sequencer.sv
// Directed bench for phys_step_sequencer: 4 slots, RD_LAT=2, behavioural RAM and update stage.
module tb_phys_step_sequencer;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic signed [9:0] time_step;
    logic [3:0]  obj_active;
    logic        busy, done, rd_en, wr_en;
    logic [1:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data, upd_dyn, upd_result;
    logic signed [9:0] upd_time_step;

    int total = 0;
    int bad   = 0;

    phys_step_sequencer #(.NUM_OBJ(4), .RD_LAT(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .time_step(time_step), .obj_active(obj_active),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .upd_dyn(upd_dyn),
        .upd_time_step(upd_time_step), .upd_result(upd_result)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [63:0] mk(input int px, input int py, input int vx, input int vy);
        return {px[15:0], py[15:0], vx[15:0], vy[15:0]};
    endfunction

    // Update stage: explicit Euler, gravity of 1.0 on vel_y, dt has 8 fraction bits.
    function automatic logic [63:0] upd_model(input logic [63:0] w, input logic signed [9:0] dt);
        int px, py, vx, vy, d;
        px = int'($signed(w[63:48]));
        py = int'($signed(w[47:32]));
        vx = int'($signed(w[31:16]));
        vy = int'($signed(w[15:0]));
        d  = int'(dt);
        px = px + ((vx * d) >>> 8);
        py = py + ((vy * d) >>> 8);
        vy = vy + ((256 * d) >>> 8);
        return {px[15:0], py[15:0], vx[15:0], vy[15:0]};
    endfunction

    assign upd_result = upd_model(upd_dyn, upd_time_step);

    // RAM: read data appears two cycles after the strobe, zero otherwise.
    logic [63:0] mem [0:3];
    logic [63:0] rd_p1 = '0;
    logic [63:0] rd_q  = '0;
    always @(posedge sys_clk) begin
        rd_p1 <= rd_en ? mem[rd_addr] : 64'd0;
        rd_q  <= rd_p1;
    end
    assign rd_data = rd_q;

    logic [1:0]  log_addr [0:63];
    logic [63:0] log_data [0:63];
    int wr_cnt   = 0;
    int done_cnt = 0;
    int overlap  = 0;
    always @(posedge sys_clk) begin
        if (wr_en) begin
            log_addr[wr_cnt % 64] <= wr_addr;
            log_data[wr_cnt % 64] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (rd_en && wr_en) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick;
            n++;
        end
        check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        tick;
    endtask

    int wr0, dn0;
    logic [63:0] exp_clamp;

    initial begin
        mem[0] = mk(100, 200, 10, -5);
        mem[1] = mk(-300, 50, 20, 0);
        mem[2] = mk(1, 999, 3, 5000);
        mem[3] = mk(-1, -2, -3, -4);
        sys_rst_n  = 1'b0;
        start      = 1'b0;
        time_step  = '0;
        obj_active = '0;
        #1;
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_done",  {63'd0, done},  64'd0);
        check("rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_upd_dyn", upd_dyn, 64'd0);
        tick; tick;
        sys_rst_n = 1'b1;
        tick;

        // Skip pattern 1011, dt=0: slot timeline 0..4, 5..9, 10, 11..15, final scan 16, DONE 17.
        time_step  = 10'sd0;
        obj_active = 4'b1011;
        start      = 1'b1;
        tick;
        start = 1'b0;
        for (int e = 0; e < 20; e++) begin
            check($sformatf("skip_busy_e%0d", e),  {63'd0, busy},  {63'd0, (e <= 17)});
            check($sformatf("skip_done_e%0d", e),  {63'd0, done},  {63'd0, (e == 17)});
            check($sformatf("skip_rd_en_e%0d", e), {63'd0, rd_en}, {63'd0, (e == 0 || e == 5 || e == 11)});
            check($sformatf("skip_wr_en_e%0d", e), {63'd0, wr_en}, {63'd0, (e == 4 || e == 9 || e == 15)});
            if (e == 11) check("skip_rd_addr_3", {62'd0, rd_addr}, 64'd3);
            if (e == 4) begin
                check("skip_wr_addr_0", {62'd0, wr_addr}, 64'd0);
                check("skip_wr_data_0", wr_data, mk(100, 200, 10, -5));
            end
            if (e == 9) begin
                check("skip_wr_addr_1", {62'd0, wr_addr}, 64'd1);
                check("skip_wr_data_1", wr_data, mk(-300, 50, 20, 0));
            end
            if (e == 15) begin
                check("skip_wr_addr_3", {62'd0, wr_addr}, 64'd3);
                check("skip_wr_data_3", wr_data, mk(-1, -2, -3, -4));
            end
            tick;
        end

        // Gravity: vel_y 0 -> 1.0 after dt = 1.0.
        wr0 = wr_cnt;
        time_step  = 10'sd256;
        obj_active = 4'b0010;
        start      = 1'b1;
        tick;
        start = 1'b0;
        wait_done(40, "grav");
        check("grav_wr_count", 64'(wr_cnt - wr0), 64'd1);
        check("grav_wr_addr", {62'd0, log_addr[wr0 % 64]}, 64'd1);
        check("grav_wr_data", log_data[wr0 % 64], mk(-280, 50, 20, 256));
        check("grav_upd_ts", 64'(upd_time_step), 64'd256);

        // Start while busy is ignored.
        wr0 = wr_cnt;
        dn0 = done_cnt;
        time_step  = 10'sd0;
        obj_active = 4'b0101;
        start      = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        obj_active = 4'b1111;
        start      = 1'b1;
        tick;
        start = 1'b0;
        wait_done(60, "busy_start");
        for (int k = 0; k < 10; k++) tick;
        check("busy_start_done_count", 64'(done_cnt - dn0), 64'd1);
        check("busy_start_wr_count", 64'(wr_cnt - wr0), 64'd2);
        check("busy_start_addr0", {62'd0, log_addr[wr0 % 64]}, 64'd0);
        check("busy_start_addr1", {62'd0, log_addr[(wr0 + 1) % 64]}, 64'd2);
        check("busy_start_idle", {63'd0, busy}, 64'd0);

        // Floor case: pos_y 999 + 5000*1.0 lands far below the floor.
        wr0 = wr_cnt;
        time_step  = 10'sd256;
        obj_active = 4'b0100;
        start      = 1'b1;
        tick;
        start = 1'b0;
        wait_done(40, "floor");
`ifdef PHYS_FLOOR_CLAMP_EN
        exp_clamp = mk(4, 1000, 3, 0);
`else
        exp_clamp = mk(4, 5999, 3, 5256);
`endif
        check("floor_wr_count", 64'(wr_cnt - wr0), 64'd1);
        check("floor_wr_data", log_data[wr0 % 64], exp_clamp);

        // Reset while waiting on the read for slot 1.
        wr0 = wr_cnt;
        time_step  = 10'sd0;
        obj_active = 4'b1111;
        start      = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        check("mid_busy_before", {63'd0, busy}, 64'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {63'd0, busy},  64'd0);
        check("mid_rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("mid_rst_rd_addr", {62'd0, rd_addr}, 64'd0);
        check("mid_rst_upd_dyn", upd_dyn, 64'd0);
        check("mid_rst_wr_data", wr_data, 64'd0);
        check("mid_rst_upd_ts", 64'(upd_time_step), 64'd0);
        tick; tick;
        sys_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick;
        check("mid_rst_wr_count", 64'(wr_cnt - wr0), 64'd1);
        check("mid_rst_idle", {63'd0, busy}, 64'd0);

        // Restart sweeps from slot 0; dt=0 writes every word back unchanged.
        wr0 = wr_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_rd_en", {63'd0, rd_en}, 64'd1);
        check("restart_rd_addr", {62'd0, rd_addr}, 64'd0);
        wait_done(60, "restart");
        check("restart_wr_count", 64'(wr_cnt - wr0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pass_addr_%0d", k), {62'd0, log_addr[(wr0 + k) % 64]}, 64'(k));
            check($sformatf("pass_data_%0d", k), log_data[(wr0 + k) % 64], mem[k]);
        end

        check("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
